// File: rtl/des3_ctrl_pkg.sv
// Shared types and defaults for the triple-DES area-core sequencing controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package des3_ctrl_pkg;

   localparam int DES_BLK_W    = 64;
   localparam int DES_KEY_W    = 56;

   // Default core geometry: 3 DES passes x 16 rounds, one cycle of output latency.
   localparam int ROUNDS_DEF   = 48;
   localparam int ROUND_W_DEF  = 6;
   localparam int CORE_LAT_DEF = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } ctrl_state_t;

endpackage

// File: rtl/des3_ctrl_round_cnt.sv
// Loadable up-counter with terminal-count flag; drives the core round select.
// Latency: count/load take effect on the next rising edge; o_tc is combinational from the count.
// Backpressure: none; the owner gates i_inc and i_load.
// Ports: clk/reset (async active-low), i_load + i_load_val, i_inc, o_cnt, o_tc (o_cnt == TC).
module des3_ctrl_round_cnt #(
   parameter int W  = 6,
   parameter int TC = 47
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == W'(TC));

endmodule

// File: rtl/des3_area_ctrl.sv
// Sequencing controller for the iterative triple-DES core: registers one block + keys, walks roundSel 0..ROUNDS-1, captures the result.
// Latency: accept edge to out_valid = ROUNDS + CORE_LAT cycles; one block in flight at a time.
// Backpressure: in_ready is low from accept until the output handshake; out_data is held while out_valid && !out_ready.
// Ports: in_* valid/ready input block, out_* valid/ready result, core_* drive/observe des3_area, busy = RUN or DRAIN.
// Optional: define DES3_CTRL_STATS_EN to add blk_count (wrapping handshake count) and stall_cycles (saturating DONE stalls).
module des3_area_ctrl
   import des3_ctrl_pkg::*;
#(
   parameter int ROUNDS   = ROUNDS_DEF,
   parameter int ROUND_W  = ROUND_W_DEF,
   parameter int CORE_LAT = CORE_LAT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DES_BLK_W-1:0] in_data,
   input  logic [DES_KEY_W-1:0] in_key1,
   input  logic [DES_KEY_W-1:0] in_key2,
   input  logic [DES_KEY_W-1:0] in_key3,
   input  logic                 in_decrypt,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DES_BLK_W-1:0] out_data,
   output logic [DES_BLK_W-1:0] core_desIn,
   output logic [DES_KEY_W-1:0] core_key1,
   output logic [DES_KEY_W-1:0] core_key2,
   output logic [DES_KEY_W-1:0] core_key3,
   output logic                 core_decrypt,
   output logic [ROUND_W-1:0]   core_roundSel,
   input  logic [DES_BLK_W-1:0] core_desOut,
   output logic                 busy
`ifdef DES3_CTRL_STATS_EN
   ,
   output logic [31:0]          blk_count,
   output logic [31:0]          stall_cycles
`endif
);

   // A zero-latency core lets the result be captured on the last round cycle, skipping DRAIN.
   localparam bit LAT0    = (CORE_LAT == 0);
   localparam int DRAIN_W = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

   ctrl_state_t          r_state;
   ctrl_state_t          w_next;

   logic [DES_BLK_W-1:0] r_din;
   logic [DES_KEY_W-1:0] r_key1;
   logic [DES_KEY_W-1:0] r_key2;
   logic [DES_KEY_W-1:0] r_key3;
   logic                 r_dec;
   logic [DES_BLK_W-1:0] r_out;
   logic [DRAIN_W-1:0]   r_drain;

   logic                 w_accept;
   logic                 w_rnd_tc;
   logic                 w_last_round;
   logic                 w_final_drain;
   logic                 w_capture;
   logic                 w_out_hs;

   assign w_accept      = (r_state == IDLE) && in_valid;
   assign w_last_round  = (r_state == RUN) && w_rnd_tc;
   assign w_final_drain = (r_state == DRAIN) && (r_drain == DRAIN_W'(1));
   assign w_capture     = LAT0 ? w_last_round : w_final_drain;
   assign w_out_hs      = (r_state == DONE) && out_ready;

   // Round select: cleared on accept (first RUN cycle shows 0 so the core loads),
   // stepped through RUN, parked at ROUNDS-1 through DRAIN/DONE, cleared on the way back to IDLE.
   des3_ctrl_round_cnt #(
      .W  (ROUND_W),
      .TC (ROUNDS - 1)
   ) u_round_cnt (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_accept || w_out_hs),
      .i_load_val ('0),
      .i_inc      ((r_state == RUN) && !w_rnd_tc),
      .o_cnt      (core_roundSel),
      .o_tc       (w_rnd_tc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid)      w_next = RUN;
         RUN:     if (w_rnd_tc)      w_next = LAT0 ? DONE : DRAIN;
         DRAIN:   if (w_final_drain) w_next = DONE;
         DONE:    if (out_ready)     w_next = IDLE;
         default:                    w_next = IDLE;
      endcase
   end

   // Block operands stay frozen from accept until the next accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_din  <= '0;
         r_key1 <= '0;
         r_key2 <= '0;
         r_key3 <= '0;
         r_dec  <= 1'b0;
      end else if (w_accept) begin
         r_din  <= in_data;
         r_key1 <= in_key1;
         r_key2 <= in_key2;
         r_key3 <= in_key3;
         r_dec  <= in_decrypt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drain <= '0;
      end else if (w_last_round) begin
         r_drain <= DRAIN_W'(CORE_LAT);
      end else if ((r_state == DRAIN) && (r_drain != '0)) begin
         r_drain <= r_drain - DRAIN_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out <= '0;
      end else if (w_capture) begin
         r_out <= core_desOut;
      end
   end

   assign in_ready     = (r_state == IDLE);
   assign out_valid    = (r_state == DONE);
   assign busy         = (r_state == RUN) || (r_state == DRAIN);
   assign out_data     = r_out;
   assign core_desIn   = r_din;
   assign core_key1    = r_key1;
   assign core_key2    = r_key2;
   assign core_key3    = r_key3;
   assign core_decrypt = r_dec;

`ifdef DES3_CTRL_STATS_EN
   logic [31:0] r_blk_cnt;
   logic [31:0] r_stall_cnt;

   // Block count wraps naturally; stall count sticks at all-ones.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blk_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_out_hs) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
         end
         if ((r_state == DONE) && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
         end
      end
   end

   assign blk_count    = r_blk_cnt;
   assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_des3_area_ctrl.sv
// Bench for des3_area_ctrl with a behavioural stand-in for the iterative core.
// The stand-in folds every round select, operand and key into its state, so gaps,
// repeats or operand changes during a block show up as a wrong result.
module tb_des3_area_ctrl;
   import des3_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic [55:0] in_key1, in_key2, in_key3;
   logic        in_decrypt;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [63:0] core_desIn;
   logic [55:0] core_key1, core_key2, core_key3;
   logic        core_decrypt;
   logic [5:0]  core_roundSel;
   logic [63:0] core_desOut;
   logic        busy;
`ifdef DES3_CTRL_STATS_EN
   logic [31:0] blk_count;
   logic [31:0] stall_cycles;
`endif

   int checks   = 0;
   int failures = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   des3_area_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_data       (in_data),
      .in_key1       (in_key1),
      .in_key2       (in_key2),
      .in_key3       (in_key3),
      .in_decrypt    (in_decrypt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .core_desIn    (core_desIn),
      .core_key1     (core_key1),
      .core_key2     (core_key2),
      .core_key3     (core_key3),
      .core_decrypt  (core_decrypt),
      .core_roundSel (core_roundSel),
      .core_desOut   (core_desOut),
      .busy          (busy)
`ifdef DES3_CTRL_STATS_EN
      ,
      .blk_count     (blk_count),
      .stall_cycles  (stall_cycles)
`endif
   );

   // Stand-in core: round 0 loads desIn, later rounds rotate; every round mixes in the
   // round number, keys and direction. Result is registered (one cycle of latency).
   function automatic logic [63:0] core_step(input logic [63:0] st, input logic [63:0] din,
                                             input logic [55:0] k1, input logic [55:0] k2,
                                             input logic [55:0] k3, input logic dec,
                                             input logic [5:0] r);
      logic [55:0] k;
      logic [63:0] base;
      k    = k1 ^ {k2[27:0], k2[55:28]} ^ {k3[13:0], k3[55:14]};
      base = (r == 6'd0) ? din : {st[62:0], st[63]};
      return base ^ {2'b00, r, k} ^ (dec ? 64'hA5A5_5A5A_0FF0_F00F : 64'h0);
   endfunction

   function automatic logic [63:0] model(input logic [63:0] din, input logic [55:0] k1,
                                         input logic [55:0] k2, input logic [55:0] k3,
                                         input logic dec);
      logic [63:0] st;
      st = '0;
      for (int r = 0; r < 48; r++) st = core_step(st, din, k1, k2, k3, dec, 6'(r));
      return st;
   endfunction

   logic [63:0] core_st = '0;
   always @(posedge clk)
      core_st <= core_step(core_st, core_desIn, core_key1, core_key2, core_key3,
                           core_decrypt, core_roundSel);
   assign core_desOut = core_st;

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Scoreboard: an output handshake happens at the next edge when both are high here.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%h required=no output", out_data);
         end else begin
            check64("sb_data", out_data, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      logic [63:0] din;
      logic [55:0] k1, k2, k3;
      logic        dec;
      int          hold;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[5];

   task automatic accept_block(input vec_t v);
      int guard;
      in_data = v.din; in_key1 = v.k1; in_key2 = v.k2; in_key3 = v.k3;
      in_decrypt = v.dec; in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
      check64("accept_wait", 64'(guard >= 200), 64'd0);
      @(posedge clk);
      exp_q.push_back(v.exp);
      #1 in_valid = 1'b0;
   endtask

   // Runs one block: accept, per-cycle sequencing checks, latency, optional stall with a
   // competing in_valid (poke), then handshake and return to IDLE.
   task automatic run_block(input vec_t v, input int hold, input bit poke);
      int cyc, seq_err, hold_err;
      logic [63:0] snap;
      out_ready = (hold == 0);
      accept_block(v);
      cyc = 0; seq_err = 0;
      while (!out_valid && cyc < 200) begin
         if (cyc < 48) begin
            if (core_roundSel !== 6'(cyc) || !busy || in_ready || core_desIn !== v.din ||
                core_key1 !== v.k1 || core_key2 !== v.k2 || core_key3 !== v.k3 ||
                core_decrypt !== v.dec)
               seq_err++;
         end
         @(posedge clk); #1; cyc++;
      end
      check64("latency", 64'(cyc), 64'd49);
      check64("round_seq_errs", 64'(seq_err), 64'd0);
      check64("rs_done", 64'(core_roundSel), 64'd47);
      snap = out_data; hold_err = 0;
      if (poke) begin in_data = ~v.din; in_valid = 1'b1; end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (out_data !== snap || !out_valid || in_ready || busy || core_desIn !== v.din)
            hold_err++;
      end
      if (hold > 0) check64("hold_errs", 64'(hold_err), 64'd0);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check64("post_hs", {61'd0, out_valid, in_ready, busy}, 64'b010);
      check64("rs_idle", 64'(core_roundSel), 64'd0);
      if (poke) check64("poke_ignored", core_desIn, v.din);
   endtask

   function automatic vec_t mkvec(input logic [63:0] din, input logic [55:0] k1,
                                  input logic [55:0] k2, input logic [55:0] k3,
                                  input logic dec, input int hold);
      vec_t v;
      v.din = din; v.k1 = k1; v.k2 = k2; v.k3 = k3; v.dec = dec; v.hold = hold;
      v.exp = model(din, k1, k2, k3, dec);
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int spur;
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
      in_key1 = '0; in_key2 = '0; in_key3 = '0; in_decrypt = 1'b0;

      vecs[0] = mkvec(64'h0, 56'h0, 56'h0, 56'h0, 1'b0, 0);
      vecs[1] = mkvec(64'h4E6F_7720_6973_2074, 56'h01_2345_6789_ABCD,
                      56'h23_4567_89AB_CDEF, 56'h45_6789_ABCD_EF01, 1'b0, 0);
      vecs[2] = mkvec(vecs[1].exp, 56'h01_2345_6789_ABCD,
                      56'h23_4567_89AB_CDEF, 56'h45_6789_ABCD_EF01, 1'b1, 0);
      vecs[3] = mkvec(64'hFFFF_FFFF_FFFF_FFFF, 56'hFF_FFFF_FFFF_FFFF,
                      56'hFF_FFFF_FFFF_FFFF, 56'hFF_FFFF_FFFF_FFFF, 1'b1, 3);
      vecs[4] = mkvec({$urandom, $urandom}, {24'($urandom), $urandom},
                      {24'($urandom), $urandom}, {24'($urandom), $urandom}, 1'b0, 0);

      #12;
      check64("rst_ctl", {60'd0, in_ready, out_valid, busy, core_decrypt}, 64'b1000);
      check64("rst_out_data", out_data, 64'h0);
      check64("rst_core_desIn", core_desIn, 64'h0);
      check64("rst_core_keys", {8'h0, core_key1 | core_key2 | core_key3}, 64'h0);
      check64("rst_roundSel", 64'(core_roundSel), 64'h0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) run_block(vecs[i], vecs[i].hold, 1'b0);

      // Long stall with a competing block offered during it.
      run_block(vecs[1], 20, 1'b1);

      // Reset in the middle of a block.
      out_ready = 1'b1;
      accept_block(vecs[4]);
      repeat (20) begin @(posedge clk); end
      #1;
      check64("rst_mid_round", 64'(core_roundSel), 64'd20);
      reset = 1'b0;
      #1;
      check64("rst_mid_ctl", {60'd0, in_ready, out_valid, busy, core_decrypt}, 64'b1000);
      check64("rst_mid_desIn", core_desIn, 64'h0);
      check64("rst_mid_roundSel", 64'(core_roundSel), 64'h0);
      check64("rst_mid_out_data", out_data, 64'h0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      spur = 0;
      repeat (60) begin @(posedge clk); #1; if (out_valid || busy) spur++; end
      check64("no_spurious", 64'(spur), 64'd0);
      run_block(vecs[2], 0, 1'b0);

`ifdef DES3_CTRL_STATS_EN
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      #1;
      check64("stats_rst", {blk_count, stall_cycles}, 64'h0);
      run_block(vecs[0], 0, 1'b0);
      run_block(vecs[1], 5, 1'b0);
      run_block(vecs[4], 0, 1'b0);
      check64("blk_count", 64'(blk_count), 64'd3);
      check64("stall_cycles", 64'(stall_cycles), 64'd5);
`endif

      repeat (3) @(posedge clk);
      #1;
      check64("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
